ifu_fetch: RTL and testbench

- Instruction fetch unit. Owns the PC and acts as the AXI-lite read master in front of the instruction SRAM slave.
- Fetches one 32-bit instruction at a time and hands {pc, inst} to the decode stage over a valid/ready handshake.
- Accepts PC redirects from the execute/writeback stage (branch, jump, trap).
- Write channels are present for bus uniformity and are tied off.

---
 rtl/ifu_pkg.sv | 18 +
 rtl/ifu_defines.svh | 13 +
 rtl/ifu_pc_reg.sv | 49 ++++
 rtl/ifu_fetch.sv | 222 ++++++++++++++++++++++
 tb/tb_ifu_fetch.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/ifu_pkg.sv
// ifu_pkg: shared types for the instruction fetch unit.
//   ifu_state_e  - fetch FSM states (REQ, RESP, HOLD)
//   resp_is_okay - true when an AXI read response is OKAY
`include "ifu_defines.svh"

package ifu_pkg;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_RESP = 2'd1,
    ST_HOLD = 2'd2
  } ifu_state_e;

  function automatic logic resp_is_okay(input logic `AXI_RESP_BUS resp);
    return (resp == `RESP_OKAY);
  endfunction

endpackage

// File: rtl/ifu_defines.svh
// Shared bus-width and constant definitions for the instruction fetch unit.
// Guarded so that every file can include it independently.
`ifndef IFU_DEFINES_SVH
`define IFU_DEFINES_SVH

`define AXI_ADDR_BUS  [31:0]
`define AXI_DATA_BUS  [31:0]
`define AXI_RESP_BUS  [1:0]
`define AXI_WSTRB_BUS [3:0]
`define INST_NOP      32'h0000_0013
`define RESP_OKAY     2'b00

`endif

// File: rtl/ifu_pc_reg.sv
// ifu_pc_reg: program counter register of the fetch unit.
// Ports:
//   clk, rst        - core clock, asynchronous active-high reset
//   i_advance       - step pc by PC_STEP (instruction consumed)
//   i_redirect      - load i_redirect_pc; has priority over i_advance
//   i_redirect_pc   - redirect target
//   o_pc            - current pc
//   o_pc_nxt        - value pc takes at the next clock edge
module ifu_pc_reg #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_advance,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc_nxt
);

  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;

  // Next-pc selection: a redirect always beats the sequential step.
  always_comb begin
    w_pc_nxt = r_pc;
    if (i_redirect) begin
      w_pc_nxt = i_redirect_pc;
    end else if (i_advance) begin
      w_pc_nxt = r_pc + 32'(PC_STEP);
    end else begin
      w_pc_nxt = r_pc;
    end
  end

  // PC state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= w_pc_nxt;
    end
  end

  assign o_pc     = r_pc;
  assign o_pc_nxt = w_pc_nxt;

endmodule

// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch unit. Owns the pc, issues one AXI-lite read
// at a time to the instruction SRAM and hands {inst_pc, inst} to decode
// over a valid/ready handshake. Accepts pc redirects at any time.
// Ports:
//   clk, rst                      - core clock, async active-high reset
//   araddr/arvalid/arready        - AR channel (address = pc)
//   rdata/rresp/rvalid/rready     - R channel
//   aw*/w*/b*                     - write channels, tied off / ignored
//   redirect_valid/redirect_pc    - pc redirect pulse and target
//   inst_valid/inst_ready/inst/inst_pc/inst_fault - decode interface
// Optional: define IFU_PERF_CNT_EN to add 64-bit perf counters
//   perf_fetch_cnt / perf_stall_cnt.
`include "ifu_defines.svh"

module ifu_fetch
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic `AXI_ADDR_BUS    araddr,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic `AXI_DATA_BUS    rdata,
  input  logic `AXI_RESP_BUS    rresp,
  input  logic                  rvalid,
  output logic                  rready,
  output logic `AXI_ADDR_BUS    awaddr,
  output logic                  awvalid,
  input  logic                  awready,
  output logic `AXI_DATA_BUS    wdata,
  output logic `AXI_WSTRB_BUS   wstrb,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic                  bvalid,
  input  logic `AXI_RESP_BUS    bresp,
  output logic                  bready,
  input  logic                  redirect_valid,
  input  logic [31:0]           redirect_pc,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [31:0]           inst,
  output logic [31:0]           inst_pc,
`ifdef IFU_PERF_CNT_EN
  output logic [63:0]           perf_fetch_cnt,
  output logic [63:0]           perf_stall_cnt,
`endif
  output logic                  inst_fault
);

  ifu_state_e  r_state;
  ifu_state_e  w_state_nxt;
  logic        r_discard;
  logic        w_discard_nxt;
  logic        r_arvalid;
  logic        r_rready;
  logic        r_inst_valid;
  logic [31:0] r_araddr;
  logic [31:0] r_inst;
  logic [31:0] r_inst_pc;
  logic        r_inst_fault;
  logic        w_advance;
  logic        w_latch;
  logic        w_ar_reload;
  logic [31:0] w_pc;
  logic [31:0] w_pc_nxt;
  logic        w_unused_in;

  ifu_pc_reg #(
    .RESET_PC (RESET_PC),
    .PC_STEP  (PC_STEP)
  ) u_pc_reg (
    .clk           (clk),
    .rst           (rst),
    .i_advance     (w_advance),
    .i_redirect    (redirect_valid),
    .i_redirect_pc (redirect_pc),
    .o_pc          (w_pc),
    .o_pc_nxt      (w_pc_nxt)
  );

  // FSM next state, discard tracking and datapath strobes.
  always_comb begin
    w_state_nxt   = r_state;
    w_discard_nxt = r_discard;
    w_advance     = 1'b0;
    w_latch       = 1'b0;
    w_ar_reload   = 1'b0;
    case (r_state)
      ST_REQ: begin
        if (r_arvalid && arready) begin
          w_state_nxt = ST_RESP;
          if (redirect_valid) begin
            w_discard_nxt = 1'b1;
          end else begin
            w_discard_nxt = r_discard;
          end
        end else if (redirect_valid) begin
          // Once the AR is on the bus it must complete; its data is dropped.
          // Before that (first cycle out of reset) just retarget the address.
          if (r_arvalid) begin
            w_discard_nxt = 1'b1;
          end else begin
            w_ar_reload = 1'b1;
          end
        end else begin
          w_state_nxt = ST_REQ;
        end
      end
      ST_RESP: begin
        if (rvalid && r_rready) begin
          if (r_discard || redirect_valid) begin
            w_state_nxt   = ST_REQ;
            w_discard_nxt = 1'b0;
          end else begin
            w_state_nxt = ST_HOLD;
            w_latch     = 1'b1;
          end
        end else if (redirect_valid) begin
          w_discard_nxt = 1'b1;
        end else begin
          w_state_nxt = ST_RESP;
        end
      end
      ST_HOLD: begin
        if (redirect_valid) begin
          // Counts as consumed if inst_ready is also high; redirect_pc wins.
          w_state_nxt = ST_REQ;
        end else if (inst_ready) begin
          w_state_nxt = ST_REQ;
          w_advance   = 1'b1;
        end else begin
          w_state_nxt = ST_HOLD;
        end
      end
      default: begin
        w_state_nxt   = ST_REQ;
        w_discard_nxt = 1'b0;
      end
    endcase
  end

  // FSM state, handshake outputs and the instruction holding register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_REQ;
      r_discard    <= 1'b0;
      r_arvalid    <= 1'b0;
      r_rready     <= 1'b0;
      r_inst_valid <= 1'b0;
      r_araddr     <= RESET_PC;
      r_inst       <= `INST_NOP;
      r_inst_pc    <= RESET_PC;
      r_inst_fault <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_discard    <= w_discard_nxt;
      r_arvalid    <= (w_state_nxt == ST_REQ);
      r_rready     <= (w_state_nxt == ST_RESP);
      r_inst_valid <= (w_state_nxt == ST_HOLD);
      // araddr is captured on entry to REQ so it cannot move while the AR
      // is pending, even if a redirect updates pc in the meantime.
      if (((r_state != ST_REQ) && (w_state_nxt == ST_REQ)) || w_ar_reload) begin
        r_araddr <= w_pc_nxt;
      end
      if (w_latch) begin
        r_inst       <= rdata;
        r_inst_pc    <= w_pc;
        r_inst_fault <= !resp_is_okay(rresp);
      end
    end
  end

`ifdef IFU_PERF_CNT_EN
  logic [63:0] r_perf_fetch;
  logic [63:0] r_perf_stall;
  logic        w_fetch_inc;
  logic        w_stall_inc;

  assign w_fetch_inc = r_inst_valid && inst_ready;
  assign w_stall_inc = (r_state == ST_REQ) || (r_state == ST_RESP);

  // Performance counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_fetch <= 64'd0;
      r_perf_stall <= 64'd0;
    end else begin
      if (w_fetch_inc) begin
        r_perf_fetch <= r_perf_fetch + 64'd1;
      end
      if (w_stall_inc) begin
        r_perf_stall <= r_perf_stall + 64'd1;
      end
    end
  end

  assign perf_fetch_cnt = r_perf_fetch;
  assign perf_stall_cnt = r_perf_stall;
`endif

  assign araddr     = r_araddr;
  assign arvalid    = r_arvalid;
  assign rready     = r_rready;
  assign inst_valid = r_inst_valid;
  assign inst       = r_inst;
  assign inst_pc    = r_inst_pc;
  assign inst_fault = r_inst_fault;

  // Write channels exist only for bus uniformity.
  assign awaddr  = 32'h0000_0000;
  assign awvalid = 1'b0;
  assign wdata   = 32'h0000_0000;
  assign wstrb   = 4'h0;
  assign wvalid  = 1'b0;
  assign bready  = 1'b1;

  assign w_unused_in = ^{awready, wready, bvalid, bresp};

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed self-checking bench for ifu_fetch. A behavioural AXI-lite slave
// answers AR after 1 cycle and R 2 cycles after the AR handshake; the word
// returned for address A is {A[15:0], 16'hC0DE}, with rresp = 2'b10 at
// fault_addr.
module tb_ifu_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic        bvalid;
  logic [1:0]  bresp;
  logic        bready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_fault;

  logic [31:0] fault_addr;
  logic [31:0] s_addr;
  logic        s_pend;
  int          n_tests = 0;
  int          n_fail  = 0;
  bit          saw_iv;

  ifu_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .araddr         (araddr),
    .arvalid        (arvalid),
    .arready        (arready),
    .rdata          (rdata),
    .rresp          (rresp),
    .rvalid         (rvalid),
    .rready         (rready),
    .awaddr         (awaddr),
    .awvalid        (awvalid),
    .awready        (awready),
    .wdata          (wdata),
    .wstrb          (wstrb),
    .wvalid         (wvalid),
    .wready         (wready),
    .bvalid         (bvalid),
    .bresp          (bresp),
    .bready         (bready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_fault     (inst_fault)
  );

  always #5 clk = ~clk;

  // Slave: acts on negedges, so its outputs are stable around each posedge.
  initial begin
    arready = 1'b0;
    rvalid  = 1'b0;
    rdata   = 32'h0000_0000;
    rresp   = 2'b00;
    s_pend  = 1'b0;
    s_addr  = 32'h0000_0000;
    forever begin
      @(negedge clk);
      if (rst) begin
        arready = 1'b0;
        rvalid  = 1'b0;
        s_pend  = 1'b0;
      end else if (rvalid) begin
        rvalid = 1'b0;          // rready is high throughout RESP
        s_pend = 1'b0;
      end else if (arready) begin
        arready = 1'b0;         // AR handshake happened at the last posedge
        s_pend  = 1'b1;
      end else if (s_pend) begin
        rvalid = 1'b1;
        rdata  = {s_addr[15:0], 16'hC0DE};
        rresp  = (s_addr == fault_addr) ? 2'b10 : 2'b00;
      end else if (arvalid) begin
        arready = 1'b1;
        s_addr  = araddr;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_ar(input string tag, input logic [31:0] exp_addr, output bit saw);
    int n = 0;
    saw = 1'b0;
    while (arvalid !== 1'b1 && n < 20) begin
      if (inst_valid === 1'b1) saw = 1'b1;
      @(negedge clk);
      n++;
    end
    chk({tag, "_arvalid"}, {31'd0, arvalid}, 32'd1);
    chk({tag, "_araddr"}, araddr, exp_addr);
  endtask

  task automatic wait_inst(input string tag, input logic [31:0] exp_pc,
                           input logic [31:0] exp_inst, input logic exp_fault);
    int n = 0;
    while (inst_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, {31'd0, inst_valid}, 32'd1);
    chk({tag, "_inst"}, inst, exp_inst);
    chk({tag, "_pc"}, inst_pc, exp_pc);
    chk({tag, "_fault"}, {31'd0, inst_fault}, {31'd0, exp_fault});
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_arvalid"}, {31'd0, arvalid}, 32'd0);
    chk({tag, "_rready"}, {31'd0, rready}, 32'd0);
    chk({tag, "_ivalid"}, {31'd0, inst_valid}, 32'd0);
    chk({tag, "_inst"}, inst, 32'h0000_0013);
    chk({tag, "_ipc"}, inst_pc, 32'h8000_0000);
    chk({tag, "_ifault"}, {31'd0, inst_fault}, 32'd0);
    chk({tag, "_araddr"}, araddr, 32'h8000_0000);
  endtask

  initial begin
    rst            = 1'b1;
    inst_ready     = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0000_0000;
    awready        = 1'b0;
    wready         = 1'b0;
    bvalid         = 1'b0;
    bresp          = 2'b00;
    fault_addr     = 32'h8000_0004;

    // Reset state and write-channel tie-offs.
    repeat (2) @(negedge clk);
    chk_reset_vals("rst");
    chk("tie_awvalid", {31'd0, awvalid}, 32'd0);
    chk("tie_wvalid", {31'd0, wvalid}, 32'd0);
    chk("tie_awaddr", awaddr, 32'h0000_0000);
    chk("tie_wdata", wdata, 32'h0000_0000);
    chk("tie_wstrb", {28'd0, wstrb}, 32'd0);
    chk("tie_bready", {31'd0, bready}, 32'd1);
    #1 rst = 1'b0;

    // Sequential fetch with inst_ready tied high; 0x8000_0004 faults.
    wait_ar("seq0_ar", 32'h8000_0000, saw_iv);
    wait_inst("seq0_inst", 32'h8000_0000, 32'h0000_C0DE, 1'b0);
    wait_ar("seq1_ar", 32'h8000_0004, saw_iv);
    wait_inst("seq1_inst", 32'h8000_0004, 32'h0004_C0DE, 1'b1);
    wait_ar("seq2_ar", 32'h8000_0008, saw_iv);
    wait_inst("seq2_inst", 32'h8000_0008, 32'h0008_C0DE, 1'b0);
    wait_ar("seq3_ar", 32'h8000_000C, saw_iv);

    // Decode stalls for 5 cycles in HOLD.
    inst_ready = 1'b0;
    wait_inst("stall_inst", 32'h8000_000C, 32'h000C_C0DE, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", {31'd0, inst_valid}, 32'd1);
      chk("stall_inst", inst, 32'h000C_C0DE);
      chk("stall_pc", inst_pc, 32'h8000_000C);
      chk("stall_noar", {31'd0, arvalid}, 32'd0);
    end
    inst_ready = 1'b1;
    wait_ar("stall_next_ar", 32'h8000_0010, saw_iv);

    // Redirect while waiting for the response: in-flight data is dropped.
    @(negedge clk);
    chk("rdir_resp_rready", {31'd0, rready}, 32'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0100;
    @(negedge clk);
    redirect_valid = 1'b0;
    wait_ar("rdir_resp_ar", 32'h8000_0100, saw_iv);
    chk("rdir_resp_dropped", {31'd0, saw_iv}, 32'd0);
    wait_inst("rdir_resp_inst", 32'h8000_0100, 32'h0100_C0DE, 1'b0);

    // Redirect in the same cycle as inst_ready in HOLD.
    wait_ar("rdir_hold_ar0", 32'h8000_0104, saw_iv);
    inst_ready = 1'b0;
    wait_inst("rdir_hold_inst", 32'h8000_0104, 32'h0104_C0DE, 1'b0);
    inst_ready     = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0200;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("rdir_hold_drop", {31'd0, inst_valid}, 32'd0);
    wait_ar("rdir_hold_ar1", 32'h8000_0200, saw_iv);
    chk("rdir_hold_once", {31'd0, saw_iv}, 32'd0);

    // Reset pulse while in RESP.
    @(negedge clk);
    chk("mid_rst_rready", {31'd0, rready}, 32'd1);
    #2 rst = 1'b1;
    #1 chk_reset_vals("mid_rst");
    @(negedge clk);
    #1 rst = 1'b0;
    wait_ar("post_rst_ar", 32'h8000_0000, saw_iv);
    wait_inst("post_rst_inst", 32'h8000_0000, 32'h0000_C0DE, 1'b0);
    wait_ar("post_rst_ar1", 32'h8000_0004, saw_iv);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
